// File: rtl/data_memory_responder.sv
// data_memory_responder: handshaked 64-bit doubleword data memory with a
// fixed access latency plus misalignment and range checking.
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 7,
    parameter int LATENCY    = 3
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [3:0]            count;
    logic                  write_q;
    logic [63:0]           addr_q;
    logic [63:0]           wdata_q;
    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] index;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad;
    logic                  access;
    logic                  accept;

    assign index        = addr_q[DEPTH_LOG2+2:3];
    assign misaligned   = addr_q[2:0] != 3'd0;
    assign out_of_range = addr_q[63:DEPTH_LOG2+3] != '0;
    assign bad          = misaligned || out_of_range;

    // Held low through reset so nothing is accepted before the FSM is known.
    assign req_ready = resetl && (state == IDLE);
    assign accept    = req_ready && req_valid;
    assign access    = resetl && (state == WAIT) && (count == 4'd0);

    // Request capture; only sampled on the accepting edge.
    always_ff @(posedge CLK) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Storage write at the end of the latency window; never cleared.
    always_ff @(posedge CLK) begin
        if (access && write_q && !bad) begin
            mem[index] <= wdata_q;
        end
    end

    // Control FSM and registered response outputs.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state      <= IDLE;
            count      <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= WAIT;
                        count <= COUNT_LOAD;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= bad;
                        resp_rdata <= (bad || write_q) ? 64'd0 : mem[index];
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed and random load/store traffic against
// a word-array reference model, on LATENCY=3 and LATENCY=1 instances.
module tb_data_memory_responder;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_error;
    logic [63:0] resp_rdata;
    logic        req_ready1, resp_valid1, resp_error1;
    logic [63:0] resp_rdata1;

    int errors = 0;
    int checks = 0;

    logic [63:0] mref [128];

    always #5 CLK = ~CLK;

    data_memory_responder #(.DEPTH_LOG2(7), .LATENCY(LAT)) dut (
        .CLK(CLK), .resetl(resetl),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_memory_responder #(.DEPTH_LOG2(7), .LATENCY(1)) dut1 (
        .CLK(CLK), .resetl(resetl),
        .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_error(resp_error1)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 1 KiB of doublewords, errors for misaligned or >= 1 KiB.
    task automatic model(input logic w, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] r,
                         output logic e);
        e = (a % 8 != 0) || (a >= 64'd1024);
        r = 64'd0;
        if (!e) begin
            if (w) mref[a / 8] = d;
            else   r = mref[a / 8];
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(req_ready && req_ready1) && n < 50) begin
            step();
            n++;
        end
        chk(tag, {64'd0, req_ready && req_ready1}, 65'd1);
    endtask

    task automatic txn(input string tag, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input int stall);
        logic [63:0] er, r1, hr;
        logic        ee, e1, he;
        int          n, n1;
        logic        held;
        model(w, a, d, er, ee);
        wait_ready({tag, "_ready"});
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = (stall == 0);
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n  = 0;
        n1 = 0;
        r1 = 'x;
        e1 = 1'bx;
        while (!resp_valid && n < 40) begin
            if (resp_valid1 && n1 == 0) begin
                n1 = n;
                r1 = resp_rdata1;
                e1 = resp_error1;
            end
            step();
            n++;
        end
        chk({tag, "_lat"}, 65'(n), 65'(LAT));
        chk({tag, "_lat1"}, 65'(n1), 65'd1);
        chk({tag, "_resp"}, {resp_error, resp_rdata}, {ee, er});
        chk({tag, "_resp1"}, {e1, r1}, {ee, er});
        hr   = resp_rdata;
        he   = resp_error;
        held = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (req_ready || !resp_valid || resp_rdata !== hr ||
                resp_error !== he) held = 1'b0;
            step();
        end
        if (stall > 0) chk({tag, "_hold"}, {64'd0, held}, 65'd1);
        resp_ready = 1'b1;
        step();
        chk({tag, "_done"}, {63'd0, resp_valid, req_ready}, 65'd1);
    endtask

    initial begin
        logic [63:0] a, d, old10, er;
        logic        ee;
        int          n;
        logic        busy_ok;

        resetl     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;

        step();
        step();
        chk("rst_out", {req_ready, resp_valid, resp_error, resp_rdata[61:0]},
            65'd0);
        chk("rst_out1", {req_ready1, resp_valid1, resp_error1,
            resp_rdata1[61:0]}, 65'd0);
        resetl = 1'b1;
        step();
        chk("rst_release", {63'd0, req_ready, req_ready1}, 65'd3);

        for (int i = 0; i < 128; i++) begin
            txn("fill", 1'b1, 64'(i * 8), {$urandom, $urandom}, 0);
        end

        txn("st28", 1'b1, 64'h28, 64'hDEADBEEFCAFEF00D, 0);
        txn("ld28", 1'b0, 64'h28, 64'h0, 0);
        chk("ld28_val", {1'b0, mref[5]}, {1'b0, 64'hDEADBEEFCAFEF00D});

        txn("bp", 1'b0, 64'h28, 64'h0, 5);
        txn("mis", 1'b0, 64'h2C, 64'h0, 0);
        txn("oor_st", 1'b1, 64'h400, 64'h1, 0);
        txn("ld0", 1'b0, 64'h0, 64'h0, 1);

        // Reset during WAIT discards the pending store.
        old10 = mref[2];
        wait_ready("rm_ready");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h10;
        req_wdata = 64'h55;
        step();
        req_valid = 1'b0;
        resetl    = 1'b0;
        step();
        chk("rm_rst", {61'd0, req_ready, resp_valid, req_ready1, resp_valid1},
            65'd0);
        resetl = 1'b1;
        resp_ready = 1'b1;
        busy_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid || resp_valid1) busy_ok = 1'b0;
            step();
        end
        chk("rm_noresp", {64'd0, busy_ok}, 65'd1);
        txn("rm_ld", 1'b0, 64'h10, 64'h0, 0);
        chk("rm_old", {1'b0, mref[2]}, {1'b0, old10});

        // Request held high through the busy period.
        d = {$urandom, $urandom};
        model(1'b1, 64'h30, d, er, ee);
        wait_ready("busy_ready");
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 64'h30;
        req_wdata  = d;
        resp_ready = 1'b1;
        step();
        req_write = 1'b0;
        req_wdata = 64'h0;
        busy_ok = 1'b1;
        n = 0;
        while (!resp_valid && n < 40) begin
            if (req_ready) busy_ok = 1'b0;
            step();
            n++;
        end
        chk("busy_lat", 65'(n), 65'(LAT));
        chk("busy_st", {resp_error, resp_rdata}, 65'd0);
        if (req_ready) busy_ok = 1'b0;
        step();
        chk("busy_noacc", {64'd0, busy_ok}, 65'd1);
        chk("busy_idle", {63'd0, req_ready, resp_valid}, 65'd2);
        step();
        req_valid = 1'b0;
        chk("busy_acc", {64'd0, req_ready}, 65'd0);
        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        chk("busy_lat2", 65'(n), 65'(LAT));
        chk("busy_ld", {resp_error, resp_rdata}, {1'b0, d});
        for (int i = 0; i < 4; i++) step();

        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 9);
            a = 64'($urandom_range(0, 127)) * 8;
            if (k == 0) a = a | 64'($urandom_range(1, 7));
            if (k == 1) a = a | (64'd1 << $urandom_range(10, 63));
            txn("rnd", 1'($urandom), a, {$urandom, $urandom},
                $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
